// File: rtl/mul_sched.sv
// mul_sched: round-robin arbiter sharing one 8x8 multiplier among NREQ requesters,
// holding operands LAT cycles and returning the tagged 16-bit product.
module mul_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_result,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              busy
);
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t         state;
  logic [IDW-1:0] rr_ptr, gnt_id, g, idx;
  logic [CW-1:0]  cnt;
  logic           found;
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign req_ready = (state == IDLE && found && !reset) ? NREQ'(1) << g : '0;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      gnt_id   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          mul_a  <= req_a[{g, 3'b000} +: 8];
          mul_b  <= req_b[{g, 3'b000} +: 8];
          gnt_id <= g;
          cnt    <= CW'(LAT - 1);
          state  <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          rsp_data <= mul_result;
          rsp_id   <= gnt_id;
          state    <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          state  <= IDLE;
          rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed table and sequence checks for the shared-multiplier scheduler.
module tb_mul_sched;
  localparam int NREQ = 4, LAT = 2, IDW = 2;
  logic            clock = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [31:0]     req_a = '0, req_b = '0;
  logic [7:0]      mul_a, mul_b;
  logic [15:0]     mul_result, rsp_data;
  logic            rsp_valid, rsp_ready = 1'b1, busy;
  logic [IDW-1:0]  rsp_id;
  int              cyc = 0, tests = 0, fails = 0;

  mul_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  // stand-in for the shared multiplier array
  assign mul_result = {8'd0, mul_a} * {8'd0, mul_b};
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [7:0]  a, b;
    logic [15:0] p;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic put(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
  endtask

  // entered at a negedge; returns at the negedge of the first RESP cycle
  task automatic wait_rsp(input string nm, input int id, input logic [15:0] p, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        n = k;
        break;
      end
      step();
      smp();
    end
    chk({nm, "_seen"}, 32'(n != 0), 32'd1);
    chk({nm, "_data"}, 32'(rsp_data), 32'(p));
    chk({nm, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  task automatic do_op(input vec_t v);
    int n;
    req_a = $urandom;
    req_b = $urandom;
    put(v.id, v.a, v.b);
    req_valid = NREQ'(1) << v.id;
    rsp_ready = 1'b1;
    smp();
    chk("grant", 32'(req_ready), 32'(NREQ'(1) << v.id));
    step();
    req_valid = '0;
    req_a = $urandom;
    req_b = $urandom;
    smp();
    chk("mul_a", 32'(mul_a), 32'(v.a));
    chk("mul_b", 32'(mul_b), 32'(v.b));
    chk("busy_op", 32'(busy), 32'd1);
    wait_rsp("op", v.id, v.p, n);
    chk("latency", 32'(n), 32'(LAT + 1));
    step();
    smp();
    chk("busy_after", 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    int n, gi, ri, last, gid;
    int ord[5];
    logic [15:0] pr[4];
    logic saw;
    vt[0] = '{0, 8'd200, 8'd255, 16'hC738};
    vt[1] = '{1, 8'd255, 8'd255, 16'hFE01};
    vt[2] = '{2, 8'd0,   8'd173, 16'h0000};
    vt[3] = '{3, 8'd100, 8'd100, 16'h2710};
    vt[4] = '{0, 8'd3,   8'd7,   16'h0015};
    vt[5] = '{1, 8'd16,  8'd16,  16'h0100};
    ord = '{0, 1, 2, 3, 0};
    pr  = '{16'h001E, 16'h0064, 16'h00D2, 16'h0168};

    step();
    step();
    reset = 1'b0;
    smp();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    step();

    for (int i = 0; i < 6; i++) do_op(vt[i]);

    // response held for 10 cycles while others request
    put(1, 8'd12, 8'd12);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    smp();
    chk("hold_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1101;
    smp();
    wait_rsp("hold", 1, 16'h0090, n);
    step();
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'h90);
      chk("hold_id", 32'(rsp_id), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    smp();
    chk("release_valid", 32'(rsp_valid), 32'd1);
    step();
    smp();
    chk("release_idle", 32'(busy), 32'd0);
    chk("release_grant", 32'(req_ready), 32'h4);
    #1 req_valid = '0;
    step();

    // reset in BUSY aborts the operation and clears the pointer
    put(3, 8'd5, 8'd5);
    req_valid = 4'b1000;
    smp();
    chk("rb_grant", 32'(req_ready), 32'h8);
    step();
    reset = 1'b1;
    req_valid = 4'b1111;
    smp();
    chk("rb_ready_busy", 32'(req_ready), 32'd0);
    step();
    smp();
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rb_mul_a", 32'(mul_a), 32'd0);
    chk("rb_ready_gated", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    req_valid = '0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      smp();
      saw = saw | rsp_valid;
      step();
    end
    chk("rb_no_rsp", 32'(saw), 32'd0);

    // all four requesting continuously
    for (int i = 0; i < 4; i++) put(i, 8'(10 * (i + 1)), 8'(2 * i + 3));
    req_valid = 4'b1111;
    gi = 0;
    ri = 0;
    last = 0;
    for (int k = 0; k < 60 && ri < 5; k++) begin
      smp();
      if (|(req_ready & req_valid)) begin
        gid = 0;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) gid = j;
        if (gi < 5) chk("rr_order", 32'(gid), 32'(ord[gi]));
        if (gi > 0) chk("rr_interval", 32'(cyc - last), 32'(LAT + 2));
        last = cyc;
        gi++;
      end
      if (rsp_valid) begin
        if (ri < 5) chk("rr_rsp_id", 32'(rsp_id), 32'(ord[ri]));
        chk("rr_rsp_data", 32'(rsp_data), 32'(pr[rsp_id]));
        ri++;
      end
      step();
      if (gi >= 5) req_valid = '0;
    end
    chk("rr_responses", 32'(ri), 32'd5);

    // requester 2 pulses valid while 1 is in service
    put(1, 8'd7, 8'd11);
    put(3, 8'd9, 8'd9);
    req_valid = 4'b0010;
    smp();
    chk("drop_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0110;
    smp();
    chk("drop_ready_busy", 32'(req_ready), 32'd0);
    step();
    req_valid = '0;
    step();
    req_valid = 4'b1001;
    smp();
    chk("drop_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("drop_rsp_id", 32'(rsp_id), 32'd1);
    chk("drop_rsp_data", 32'(rsp_data), 32'h4D);
    step();
    smp();
    chk("drop_next_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    smp();
    wait_rsp("drop3", 3, 16'h0051, n);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
